// File: rtl/disp_sched_if.sv
// Display-scheduler bus: game status inputs in, BCD display word and status out.
interface disp_sched_if;
  logic       game_run;
  logic       hit;
  logic [9:0] score;
  logic [9:0] time_left;
  logic [11:0] bcd;
  logic [1:0] src;
  logic       busy;

  modport master (output game_run, hit, score, time_left, input bcd, src, busy);
  modport slave  (input game_run, hit, score, time_left, output bcd, src, busy);
endinterface

// File: rtl/disp_sched.sv
// Picks time / score / hit-flash for the 3-digit display and converts it to BCD
// with a 10-step double-dabble engine. Define HISCORE_EN for idle hiscore alternation.
module disp_sched #(
  parameter int CLK_PER_MS = 50000,
  parameter int SHOW_MS    = 2000,
  parameter int HIT_MS     = 500
) (
  input logic         clk,
  input logic         reset,
  disp_sched_if.slave bus
);
  localparam int MSW  = $clog2(CLK_PER_MS + 1);
  localparam int DMAX = (SHOW_MS > HIT_MS) ? SHOW_MS : HIT_MS;
  localparam int DW   = $clog2(DMAX + 1);

  typedef enum logic [1:0] {S_SCORE = 2'd0, S_TIME = 2'd1, S_HIT = 2'd2, S_HISCORE = 2'd3} sel_t;
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT, C_DONE} conv_t;

  logic [MSW-1:0] ms_cnt_reg;
  logic           tick;
  logic           run_reg, rise, fall;
  sel_t           sel_reg, sel_next, sel_prev_reg;
  logic [DW-1:0]  dwell_reg, dwell_next;

  assign tick = (ms_cnt_reg == MSW'(CLK_PER_MS - 1));
  assign rise = bus.game_run & ~run_reg;
  assign fall = ~bus.game_run & run_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_cnt_reg   <= '0;
      run_reg      <= 1'b0;
      sel_reg      <= S_SCORE;
      sel_prev_reg <= S_SCORE;
      dwell_reg    <= '0;
    end else begin
      ms_cnt_reg   <= tick ? '0 : ms_cnt_reg + 1'b1;
      run_reg      <= bus.game_run;
      sel_reg      <= sel_next;
      sel_prev_reg <= sel_reg;
      dwell_reg    <= dwell_next;
    end
  end

  // A hit outranks a same-cycle rising edge of game_run.
  always_comb begin
    sel_next   = sel_reg;
    dwell_next = dwell_reg;
    if (!bus.game_run) begin
      sel_next   = S_SCORE;
      dwell_next = '0;
`ifdef HISCORE_EN
      if (!fall) begin
        sel_next   = sel_reg;
        dwell_next = dwell_reg;
        if (tick) begin
          if (dwell_reg == DW'(SHOW_MS - 1)) begin
            sel_next   = (sel_reg == S_HISCORE) ? S_SCORE : S_HISCORE;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_reg + 1'b1;
          end
        end
      end
`endif
    end else if (bus.hit) begin
      sel_next   = S_HIT;
      dwell_next = '0;
    end else if (rise) begin
      sel_next   = S_TIME;
      dwell_next = '0;
    end else if (tick) begin
      case (sel_reg)
        S_HIT: begin
          if (dwell_reg == DW'(HIT_MS - 1)) begin
            sel_next   = S_TIME;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_reg + 1'b1;
          end
        end
        S_TIME, S_SCORE: begin
          if (dwell_reg == DW'(SHOW_MS - 1)) begin
            sel_next   = (sel_reg == S_TIME) ? S_SCORE : S_TIME;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_reg + 1'b1;
          end
        end
        default: begin
          sel_next   = S_TIME;
          dwell_next = '0;
        end
      endcase
    end
  end

`ifdef HISCORE_EN
  logic [9:0] hiscore_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiscore_reg <= '0;
    end else if (fall && (bus.score > hiscore_reg)) begin
      hiscore_reg <= bus.score;
    end
  end
`endif

  conv_t       c_reg, c_next;
  logic        pending_reg, pending_next;
  logic        req;
  logic [3:0]  shift_cnt_reg;
  logic [9:0]  bin_reg;
  logic [11:0] acc_reg, acc_adj;
  sel_t        src_cap_reg;
  logic [11:0] bcd_reg;
  logic [1:0]  src_reg;
  logic [9:0]  operand, operand_clamped;

  assign req = tick | (sel_reg != sel_prev_reg);

  always_comb begin
    operand = (sel_reg == S_TIME) ? bus.time_left : bus.score;
`ifdef HISCORE_EN
    if (sel_reg == S_HISCORE) operand = hiscore_reg;
`endif
  end
  assign operand_clamped = (operand > 10'd999) ? 10'd999 : operand;

  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ? acc_reg[gi*4 +: 4] + 4'd3
                                                              : acc_reg[gi*4 +: 4];
  end

  // Only one request is remembered while a conversion is in flight.
  always_comb begin
    c_next       = c_reg;
    pending_next = pending_reg;
    case (c_reg)
      C_IDLE: begin
        if (req || pending_reg) begin
          c_next       = C_LOAD;
          pending_next = 1'b0;
        end
      end
      C_LOAD:  c_next = C_SHIFT;
      C_SHIFT: if (shift_cnt_reg == 4'd9) c_next = C_DONE;
      default: c_next = C_IDLE;
    endcase
    if ((c_reg != C_IDLE) && req) pending_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_reg         <= C_IDLE;
      pending_reg   <= 1'b0;
      shift_cnt_reg <= '0;
      bin_reg       <= '0;
      acc_reg       <= '0;
      src_cap_reg   <= S_SCORE;
      bcd_reg       <= '0;
      src_reg       <= '0;
    end else begin
      c_reg       <= c_next;
      pending_reg <= pending_next;
      case (c_reg)
        C_LOAD: begin
          bin_reg       <= operand_clamped;
          acc_reg       <= '0;
          src_cap_reg   <= sel_reg;
          shift_cnt_reg <= '0;
        end
        C_SHIFT: begin
          {acc_reg, bin_reg} <= {acc_adj[10:0], bin_reg, 1'b0};
          shift_cnt_reg      <= shift_cnt_reg + 1'b1;
        end
        C_DONE: begin
          bcd_reg <= acc_reg;
          src_reg <= src_cap_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd  = bcd_reg;
  assign bus.src  = src_reg;
  assign bus.busy = (c_reg == C_LOAD) || (c_reg == C_SHIFT);
endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: behavioural model compared every cycle,
// plus directed literal checks and a randomized phase.
module tb_disp_sched;
  localparam int CPM   = 10;
  localparam int SHOW  = 3;
  localparam int HITMS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  disp_sched_if bus ();

  disp_sched #(.CLK_PER_MS(CPM), .SHOW_MS(SHOW), .HIT_MS(HITMS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: 0 score, 1 time, 2 hit, 3 hiscore; phase -1 idle, 0 load, 1..10 shift, 11 done.
  int          m_cnt, m_sel, m_prev_sel, m_dwell, m_phase, m_val, m_src, m_hiscore;
  bit          m_run_prev, m_pending;
  logic [11:0] m_bcd;
  logic [1:0]  m_out_src;

  function automatic logic [11:0] to_bcd(int v);
    int c;
    c = (v > 999) ? 999 : v;
    return 12'((c / 100) * 256 + ((c / 10) % 10) * 16 + (c % 10));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_sel = 0; m_prev_sel = 0; m_dwell = 0; m_phase = -1;
      m_val = 0; m_src = 0; m_hiscore = 0; m_run_prev = 0; m_pending = 0;
      m_bcd = 12'h000; m_out_src = 2'd0;
    end else begin
      bit tick, req, rise, fall;
      int nsel, ndw;
      tick = (m_cnt == CPM - 1);
      req  = tick || (m_sel != m_prev_sel);
      rise = bus.game_run && !m_run_prev;
      fall = !bus.game_run && m_run_prev;
      // conversion job
      if (m_phase < 0) begin
        if (req || m_pending) begin
          m_phase = 0;
          m_pending = 0;
        end
      end else begin
        if (req) m_pending = 1;
        if (m_phase == 0) begin
          m_val = (m_sel == 1) ? int'(bus.time_left) : ((m_sel == 3) ? m_hiscore : int'(bus.score));
          m_src = m_sel;
        end
        if (m_phase == 11) begin
          m_bcd = to_bcd(m_val);
          m_out_src = 2'(m_src);
          m_phase = -1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      // content selection
      nsel = m_sel; ndw = m_dwell;
      if (!bus.game_run) begin
        if (fall) begin
          nsel = 0; ndw = 0;
        end
`ifdef HISCORE_EN
        else if (tick) begin
          if (m_dwell + 1 >= SHOW) begin nsel = (m_sel == 3) ? 0 : 3; ndw = 0; end
          else ndw = m_dwell + 1;
        end
`else
        else begin
          nsel = 0; ndw = 0;
        end
`endif
      end else if (bus.hit) begin
        nsel = 2; ndw = 0;
      end else if (rise) begin
        nsel = 1; ndw = 0;
      end else if (tick) begin
        if (m_dwell + 1 >= ((m_sel == 2) ? HITMS : SHOW)) begin
          nsel = (m_sel == 1) ? 0 : 1;
          ndw = 0;
        end else begin
          ndw = m_dwell + 1;
        end
      end
`ifdef HISCORE_EN
      if (fall && (int'(bus.score) > m_hiscore)) m_hiscore = int'(bus.score);
`endif
      m_prev_sel = m_sel;
      m_sel = nsel;
      m_dwell = ndw;
      m_cnt = tick ? 0 : m_cnt + 1;
      m_run_prev = bus.game_run;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_busy;
      exp_busy = (m_phase >= 0) && (m_phase <= 10);
      checks++;
      if (bus.bcd !== m_bcd || bus.src !== m_out_src || bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL model_cmp t=%0t bcd got %h exp %h src got %0d exp %0d busy got %0b exp %0b",
                 $time, bus.bcd, m_bcd, bus.src, m_out_src, bus.busy, exp_busy);
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic expect_disp(input string name, input logic [11:0] eb, input logic [1:0] es, input int bound);
    int n;
    n = 0;
    while (n < bound && !(bus.bcd === eb && bus.src === es)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(bus.bcd === eb && bus.src === es)) begin
      errors++;
      $display("FAIL %s bcd %h src %0d expected bcd %h src %0d within %0d cycles",
               name, bus.bcd, bus.src, eb, es, bound);
    end else begin
      $display("ok   %s bcd %h src %0d after %0d cycles", name, eb, es, n);
    end
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n;
    n = 0;
    while (bus.busy !== level && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== level) begin
      checks++;
      errors++;
      $display("FAIL %s busy never reached %0b", name, level);
    end
  endtask

  task automatic pulse_hit();
    @(negedge clk); bus.hit = 1'b1;
    @(negedge clk); bus.hit = 1'b0;
  endtask

  initial begin
    int busy_cnt, lat;
    bus.game_run = 1'b0; bus.hit = 1'b0; bus.score = 10'd347; bus.time_left = 10'd0;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_bcd", 32'(bus.bcd), 32'h000);
    check_val("reset_src", 32'(bus.src), 32'd0);
    check_val("reset_busy", 32'(bus.busy), 32'd0);

    // 1: first conversion after release
    reset = 1'b1;
    wait_busy(1'b1, "first_load");
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 40) begin busy_cnt++; @(negedge clk); end
    lat = busy_cnt;
    while (bus.bcd !== 12'h347 && lat < 40) begin lat++; @(negedge clk); end
    check_val("busy_len", 32'(busy_cnt), 32'd11);
    check_val("latency", 32'(lat), 32'd12);
    check_val("first_bcd", 32'(bus.bcd), 32'h347);
    check_val("first_src", 32'(bus.src), 32'd0);

    // 2: round start and alternation
    @(negedge clk);
    bus.time_left = 10'd59; bus.score = 10'd120; bus.game_run = 1'b1;
    expect_disp("time_shown", 12'h059, 2'd1, 40);
    expect_disp("score_alt", 12'h120, 2'd0, 80);
    expect_disp("time_alt", 12'h059, 2'd1, 80);

    // 3: hit flash, extended by a second hit
    @(negedge clk); bus.score = 10'd121;
    pulse_hit();
    expect_disp("hit_flash", 12'h121, 2'd2, 40);
    repeat (CPM - 1) @(negedge clk);
    pulse_hit();
    expect_disp("hit_return", 12'h059, 2'd1, 80);

    // 4: idle, clamp, zero, ignored hit
    @(negedge clk); bus.game_run = 1'b0; bus.score = 10'd1000;
    expect_disp("clamp", 12'h999, 2'd0, 100);
    pulse_hit();
    @(negedge clk); bus.score = 10'd0;
    expect_disp("zero", 12'h000, 2'd0, 100);

    // 5: reset mid-shift, then input change during shift
    wait_busy(1'b1, "rst_load");
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("abort_bcd", 32'(bus.bcd), 32'h000);
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_src", 32'(bus.src), 32'd0);
    @(negedge clk); bus.score = 10'd200; reset = 1'b1;
    wait_busy(1'b1, "inflight_load");
    repeat (3) @(negedge clk);
    bus.score = 10'd201;
    wait_busy(1'b0, "inflight_done");
    @(negedge clk);
    check_val("inflight_bcd", 32'(bus.bcd), 32'h200);
    expect_disp("pending_bcd", 12'h201, 2'd0, 40);

    // 6: two rounds, hiscore kept at the larger
    @(negedge clk); bus.score = 10'd88; bus.game_run = 1'b1;
    repeat (20) @(negedge clk);
    bus.game_run = 1'b0;
    repeat (20) @(negedge clk);
    bus.score = 10'd50; bus.game_run = 1'b1;
    repeat (20) @(negedge clk);
    bus.game_run = 1'b0;
    expect_disp("idle_score", 12'h050, 2'd0, 100);
`ifdef HISCORE_EN
    expect_disp("idle_hiscore", 12'h088, 2'd3, 100);
    expect_disp("idle_score2", 12'h050, 2'd0, 100);
`else
    repeat (100) @(negedge clk);
    check_val("idle_src", 32'(bus.src), 32'd0);
`endif

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) bus.game_run = ~bus.game_run;
      bus.hit = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) bus.score = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 19) == 0) bus.time_left = 10'($urandom_range(0, 1023));
    end
    bus.hit = 1'b0;
    repeat (30) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
